// File: rtl/lsu_data_mem_pkg.sv
// Shared types for the LSU data memory: load/store size codes, controller states
// and the funct3 legality rule.
package lsu_mem_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    CLEAR,
    READY
  } mem_state_e;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      LS_B, LS_H, LS_W: return 1'b1;
      LS_BU, LS_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_mem_if.sv
// Request/response bundle between the load/store unit and the data memory.
interface lsu_data_mem_if #(parameter int ADDR_W = 32);
  import lsu_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic              rsp_valid;
  logic [31:0]       read_data;
  logic              fault;
  logic              busy;

  modport master (
    output req_valid, req_write, req_funct3, address, write_data,
    input  req_ready, rsp_valid, read_data, fault, busy
  );

  modport slave (
    input  req_valid, req_write, req_funct3, address, write_data,
    output req_ready, rsp_valid, read_data, fault, busy
  );

endinterface

// File: rtl/lsu_data_mem_align.sv
// Byte-lane steering: store byte enables/replicated data, load extraction with
// sign/zero extension, and the misalignment check.
module lsu_align
  import lsu_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_ldata,
  output logic        o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];

   // Store data is replicated across lanes; the byte enables pick the live ones.
   always_comb begin
      o_be       = 4'b0000;
      o_wword    = i_wdata;
      o_ldata    = 32'h0;
      o_misalign = 1'b0;
      case (i_funct3)
         LS_B, LS_BU: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wword = {4{i_wdata[7:0]}};
            o_ldata = (i_funct3 == LS_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
         end
         LS_H, LS_HU: begin
            o_misalign = i_addr_lo[0];
            o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wword    = {2{i_wdata[15:0]}};
            o_ldata    = (i_funct3 == LS_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
         end
         LS_W: begin
            o_misalign = |i_addr_lo;
            o_be       = 4'b1111;
            o_ldata    = i_raw;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_data_mem.sv
// Word-organised data memory with byte-lane stores, extended loads, a one-cycle
// registered response and a sequenced zero-fill after reset.
module lsu_data_mem
  import lsu_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DEPTH_WORDS    = 512,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  lsu_data_mem_if.slave bus
);

   localparam int               IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH_WORDS - 1);

   mem_state_e       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_clr_cnt;
   logic [31:0]      r_mem [DEPTH_WORDS];
   logic             r_rsp_valid, r_fault;
   logic [31:0]      r_rdata;

   logic [IDX_W-1:0] w_idx;
   logic             w_oor, w_illegal, w_misalign, w_fault, w_accept, w_clr_we;
   logic [3:0]       w_be;
   logic [31:0]      w_wword, w_ldata, w_raw;

   assign w_idx      = bus.address[IDX_W+1:2];
   // Upper address bits must be zero; aliasing into the array would be silent corruption.
   assign w_oor      = |bus.address[ADDR_W-1:IDX_W+2];
   assign w_illegal  = !f3_legal(bus.req_write, bus.req_funct3);
   assign w_fault    = w_oor | w_illegal | w_misalign;
   assign w_accept   = bus.req_valid & bus.req_ready;
   assign w_raw      = r_mem[w_idx];

   lsu_align u_align (
      .i_funct3   (bus.req_funct3),
      .i_addr_lo  (bus.address[1:0]),
      .i_wdata    (bus.write_data),
      .i_raw      (w_raw),
      .o_be       (w_be),
      .o_wword    (w_wword),
      .o_ldata    (w_ldata),
      .o_misalign (w_misalign)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_clr_we    = 1'b0;
      case (r_state)
         CLEAR: begin
            w_clr_we = 1'b1;
            if (r_clr_cnt == LAST) w_state_nxt = READY;
         end
         READY:   ;
         default: w_state_nxt = READY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= CLEAR_ON_RESET ? CLEAR : READY;
         r_clr_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_clr_we) r_clr_cnt <= r_clr_cnt + 1'b1;
      end
   end

   // Array deliberately has no reset; zeroing is the CLEAR sequence's job.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_clr_cnt] <= 32'h0;
      end else if (w_accept && bus.req_write && !w_fault) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_fault     <= 1'b0;
         r_rdata     <= 32'h0;
      end else begin
         r_rsp_valid <= w_accept;
         r_fault     <= w_accept & w_fault;
         r_rdata     <= (w_accept && !bus.req_write && !w_fault) ? w_ldata : 32'h0;
      end
   end

   assign bus.req_ready = (r_state == READY) & ~rst;
   assign bus.busy      = (r_state == CLEAR);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.fault     = r_fault;
   assign bus.read_data = r_rdata;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed and randomized checks of lsu_data_mem against a byte-addressed
// little-endian reference memory.
module tb_lsu_data_mem;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;
   logic [7:0] mb [2048];

   lsu_data_mem_if #(.ADDR_W(32)) bus ();

   lsu_data_mem #(.ADDR_W(32), .DEPTH_WORDS(512), .CLEAR_ON_RESET(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2048; i++) mb[i] = 8'h0;
   endtask

   task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] ed, output logic ef);
      int n;
      logic legal;
      logic [31:0] v;
      n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
      ef    = !legal || (a >= 32'd2048) || ((a % n) != 0);
      ed    = 32'h0;
      if (!ef) begin
         if (wr) begin
            for (int k = 0; k < n; k++) mb[int'(a) + k] = wd[8*k +: 8];
         end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = mb[int'(a) + k];
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            ed = v;
         end
      end
   endtask

   task automatic req(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] od);
      logic [31:0] ed;
      logic ef;
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_funct3 = f3;
      bus.address    = a;
      bus.write_data = wd;
      model(wr, f3, a, wd, ed, ef);
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk({tag, ".vld"},  32'(bus.rsp_valid), 32'd1);
      chk({tag, ".data"}, bus.read_data, ed);
      chk({tag, ".flt"},  32'(bus.fault), 32'(ef));
      od = bus.read_data;
   endtask

   task automatic idle(input string tag);
      @(posedge clk); #1;
      chk({tag, ".vld"},  32'(bus.rsp_valid), 32'd0);
      chk({tag, ".data"}, bus.read_data, 32'd0);
      chk({tag, ".flt"},  32'(bus.fault), 32'd0);
   endtask

   // Counts sampled cycles with busy high; req_ready must stay low throughout.
   task automatic count_busy(output int c, output int bad);
      c = 0;
      bad = 0;
      while (bus.busy && c < 600) begin
         if (bus.req_ready) bad++;
         c++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] d;
      int c, bad;
      logic wr;
      logic [2:0] f3;
      logic [31:0] a;

      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.address    = 32'h1FC;
      bus.write_data = 32'h0;
      model_clear();

      #2 rst = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("rst.vld",   32'(bus.rsp_valid), 32'd0);
      chk("rst.data",  bus.read_data, 32'd0);
      chk("rst.flt",   32'(bus.fault), 32'd0);
      chk("rst.ready", 32'(bus.req_ready), 32'd0);
      chk("rst.busy",  32'(bus.busy), 32'd1);

      rst = 1'b0;
      count_busy(c, bad);
      chk("clr.cycles", 32'(c), 32'd512);
      chk("clr.ready_low", 32'(bad), 32'd0);
      chk("clr.ready_after", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("lw1fc.vld",  32'(bus.rsp_valid), 32'd1);
      chk("lw1fc.data", bus.read_data, 32'h0);
      chk("lw1fc.flt",  32'(bus.fault), 32'd0);
      idle("idle0");

      req("sw10",  1, 3'b010, 32'h10, 32'hDEADBEEF, d);
      req("lb13",  0, 3'b000, 32'h13, 32'h0, d);  chk("lb13.spec",  d, 32'hFFFFFFDE);
      req("lbu13", 0, 3'b100, 32'h13, 32'h0, d);  chk("lbu13.spec", d, 32'h000000DE);
      req("lh10",  0, 3'b001, 32'h10, 32'h0, d);  chk("lh10.spec",  d, 32'hFFFFBEEF);
      req("lhu12", 0, 3'b101, 32'h12, 32'h0, d);  chk("lhu12.spec", d, 32'h0000DEAD);

      req("sw20",  1, 3'b010, 32'h20, 32'h11223344, d);
      req("sb21",  1, 3'b000, 32'h21, 32'hFFFFFFAA, d);
      req("lw20a", 0, 3'b010, 32'h20, 32'h0, d);  chk("lw20a.spec", d, 32'h1122AA44);
      req("sh22",  1, 3'b001, 32'h22, 32'h12345566, d);
      req("lw20b", 0, 3'b010, 32'h20, 32'h0, d);  chk("lw20b.spec", d, 32'h5566AA44);

      req("sw22",  1, 3'b010, 32'h22, 32'hFFFFFFFF, d);
      req("lw20c", 0, 3'b010, 32'h20, 32'h0, d);  chk("lw20c.spec", d, 32'h5566AA44);
      req("lh01",  0, 3'b001, 32'h01, 32'h0, d);
      req("ld011", 0, 3'b011, 32'h00, 32'h0, d);
      req("sbu",   1, 3'b100, 32'h24, 32'h77, d);

      req("lw800", 0, 3'b010, 32'h800, 32'h0, d);
      req("sw800", 1, 3'b010, 32'h800, 32'hCAFEF00D, d);
      req("lw0",   0, 3'b010, 32'h0,   32'h0, d);  chk("lw0.spec", d, 32'h0);
      req("swhi",  1, 3'b010, 32'h8000_0010, 32'h0BADF00D, d);
      req("lw10",  0, 3'b010, 32'h10,  32'h0, d);  chk("lw10.spec", d, 32'hDEADBEEF);
      idle("idle1");

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) idle("rnd.idle");
         wr = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 255));
         req("rnd", wr, f3, a, $urandom(), d);
      end

      // Reset right after a load accept kills the pending response.
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.address    = 32'h10;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("rstld.vld_before", 32'(bus.rsp_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstld.vld",  32'(bus.rsp_valid), 32'd0);
      chk("rstld.data", bus.read_data, 32'd0);
      chk("rstld.busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 100; i++) @(negedge clk);
      chk("clr100.busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_busy(c, bad);
      chk("reclr.cycles", 32'(c), 32'd512);
      chk("reclr.ready_low", 32'(bad), 32'd0);
      model_clear();
      #1;
      req("post.lw10", 0, 3'b010, 32'h10, 32'h0, d);
      req("post.lw20", 0, 3'b010, 32'h20, 32'h0, d);
      for (int i = 0; i < 20; i++)
         req("post.rnd", 0, 3'b010, 32'($urandom_range(0, 511)) << 2, 32'h0, d);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
